ntt_out_collector: RTL and testbench

Receive-side partner of the NTT core's output stream. Captures the natural-order coefficient stream (the core's reordered data_o/is_done output) into a ping-pong pair of N-word buffers, so the core never stalls. Drains each completed polynomial to a downstream consumer over a valid/ready stream. Sits between the NTT top level and the host/DMA interface.

---
 rtl/ntt_out_collector.sv | 160 ++++++++++++++++
 tb/tb_ntt_out_collector.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_out_collector.sv
// Ping-pong capture of the NTT core's natural-order output stream, drained to a
// valid/ready consumer one polynomial at a time.
//
// state  | meaning
// IDLE   | waiting for the current read bank to be FULL
// FETCH  | read of index 0 in flight
// STREAM | m_valid high; advance one word per accepted beat
module ntt_out_collector #(
    parameter int DATA_W = 32,
    parameter int N      = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_valid,
    input  logic [DATA_W-1:0]    s_data,
    input  logic                 s_last,
    output logic                 s_ready,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [DATA_W-1:0]    m_data,
    output logic [$clog2(N)-1:0] m_index,
    output logic                 m_last,
    output logic [1:0]           banks_full,
    output logic                 overflow,
    output logic                 frame_err
);

    localparam int DEPTH = $clog2(N);
    localparam logic [DEPTH-1:0] LAST_IDX = DEPTH'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_STREAM
    } rd_state_t;

    logic [DATA_W-1:0] mem0 [N];
    logic [DATA_W-1:0] mem1 [N];

    rd_state_t         state_q;
    rd_state_t         state_d;
    logic [1:0]        full_q;
    logic [1:0]        full_d;
    logic              wr_bank_q;
    logic              rd_bank_q;
    logic [DEPTH-1:0]  wr_cnt_q;
    logic [DEPTH-1:0]  rd_addr_q;
    logic              wr_acc;
    logic              wr_close;
    logic              rd_load;
    logic              rd_done;

    assign s_ready    = ~full_q[wr_bank_q];
    assign banks_full = full_q;
    assign wr_acc     = s_valid & s_ready;
    assign wr_close   = wr_acc & (wr_cnt_q == LAST_IDX);

    // Storage arrays carry no reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            if (wr_bank_q) begin
                mem1[wr_cnt_q] <= s_data;
            end else begin
                mem0[wr_cnt_q] <= s_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The output register doubles as the RAM read register, so a stalled
    // beat simply holds it and the read address does not move.
    always_comb begin
        state_d = state_q;
        rd_load = 1'b0;
        rd_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                rd_load = 1'b1;
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (m_ready) begin
                    if (m_last) begin
                        rd_done = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        rd_load = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Closing and freeing always hit different banks, so both can land together.
    always_comb begin
        full_d = full_q;
        if (wr_close) begin
            full_d[wr_bank_q] = 1'b1;
        end
        if (rd_done) begin
            full_d[rd_bank_q] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= '0;
            rd_addr_q <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_index   <= '0;
            m_last    <= 1'b0;
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            full_q <= full_d;
            if (wr_acc) begin
                wr_cnt_q <= wr_cnt_q + DEPTH'(1);
                if (wr_close) begin
                    wr_bank_q <= ~wr_bank_q;
                end
                if (s_last != (wr_cnt_q == LAST_IDX)) begin
                    frame_err <= 1'b1;
                end
            end
            if (s_valid && !s_ready) begin
                overflow <= 1'b1;
            end
            if (rd_done) begin
                rd_bank_q <= ~rd_bank_q;
                m_valid   <= 1'b0;
                m_last    <= 1'b0;
            end
            if (rd_load) begin
                m_data    <= rd_bank_q ? mem1[rd_addr_q] : mem0[rd_addr_q];
                m_index   <= rd_addr_q;
                m_last    <= (rd_addr_q == LAST_IDX);
                m_valid   <= 1'b1;
                rd_addr_q <= rd_addr_q + DEPTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_ntt_out_collector.sv
// Directed and randomized bench for ntt_out_collector; a queue/occupancy model
// predicts accepted samples, output order, bank flags and sticky errors.
module tb_ntt_out_collector;

    localparam int N      = 8;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              s_ready;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;
    logic [2:0]        m_index;
    logic              m_last;
    logic [1:0]        banks_full;
    logic              overflow;
    logic              frame_err;

    ntt_out_collector #(.DATA_W(DATA_W), .N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_index    (m_index),
        .m_last     (m_last),
        .banks_full (banks_full),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    // Reference model: polynomials closed (wp) and drained (rp) since reset;
    // polynomial p lives in bank p%2.
    logic [DATA_W-1:0] exp_q[$];
    int wp, rp, partial, out_idx, acc_total;
    logic mdl_ovf, mdl_ferr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        wp = 0; rp = 0; partial = 0; out_idx = 0; acc_total = 0;
        mdl_ovf = 1'b0; mdl_ferr = 1'b0;
    endtask

    // Checks the current cycle against the model, advances the model, then
    // moves to 1 time unit after the next rising edge.
    task automatic tick();
        logic [1:0] exp_full;
        logic       accept;
        exp_full = 2'b00;
        for (int p = rp; p < wp; p++) exp_full[p % 2] = 1'b1;
        accept = (wp - rp) < 2;
        chk("s_ready", s_ready, accept);
        chk("banks_full", banks_full, exp_full);
        chk("overflow", overflow, mdl_ovf);
        chk("frame_err", frame_err, mdl_ferr);
        if (exp_q.size() == 0) begin
            chk("spurious_valid", m_valid, 1'b0);
        end else if (m_valid) begin
            chk("m_data", m_data, exp_q[0]);
            chk("m_index", m_index, out_idx);
            chk("m_last", m_last, out_idx == N - 1);
        end
        if (m_valid && m_ready && exp_q.size() != 0) begin
            exp_q.delete(0);
            if (out_idx == N - 1) begin
                out_idx = 0;
                rp++;
            end else begin
                out_idx++;
            end
        end
        if (s_valid) begin
            if (accept) begin
                exp_q.push_back(s_data);
                acc_total++;
                if (s_last != (partial == N - 1)) mdl_ferr = 1'b1;
                partial++;
                if (partial == N) begin
                    partial = 0;
                    wp++;
                end
            end else begin
                mdl_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DATA_W-1:0] d, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        tick();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain(input bit rand_ready, input int budget);
        int n;
        n = 0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        while (exp_q.size() != 0 && n < budget) begin
            m_ready = rand_ready ? 1'($urandom % 2) : 1'b1;
            tick();
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
        m_ready = 1'b1;
    endtask

    task automatic apply_reset();
        s_valid = 1'b0;
        s_last  = 1'b0;
        reset   = 1'b0;
        #1;
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_index", m_index, 0);
        chk("rst_m_last", m_last, 1'b0);
        chk("rst_banks_full", banks_full, 2'b00);
        chk("rst_s_ready", s_ready, 1'b1);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        model_clear();
        @(posedge clk);
        apply_reset();

        // Single polynomial, ready consumer: latency and back-to-back beats.
        for (int i = 0; i < N; i++) send(DATA_W'(16'h10 + i), i == N - 1);
        chk("t1_full_after_close", banks_full, 2'b01);
        chk("t1_valid_c0", m_valid, 1'b0);
        tick();
        chk("t1_valid_c1", m_valid, 1'b0);
        tick();
        chk("t1_valid_c2", m_valid, 1'b1);
        chk("t1_first_data", m_data, 16'h10);
        for (int i = 0; i < N; i++) tick();
        chk("t1_beats_consec", exp_q.size(), 0);
        chk("t1_valid_after", m_valid, 1'b0);
        chk("t1_full_after", banks_full, 2'b00);

        // Two polynomials with the consumer stalled, then one extra sample.
        m_ready = 1'b0;
        for (int i = 0; i < 2 * N; i++) send(DATA_W'(16'h200 + i), (i % N) == N - 1);
        chk("t2_s_ready_full", s_ready, 1'b0);
        chk("t2_banks_full", banks_full, 2'b11);
        send(16'hDEAD, 1'b0);
        chk("t2_overflow", overflow, 1'b1);
        chk("t2_queue_len", exp_q.size(), 2 * N);
        drain(1'b0, 60);

        // Random source gaps and random consumer stalls over three polynomials.
        acc_total = 0;
        for (int n = 0; n < 600 && acc_total < 3 * N; n++) begin
            s_valid = 1'(($urandom % 10) < 7);
            s_data  = DATA_W'($urandom);
            s_last  = (partial == N - 1);
            m_ready = 1'($urandom % 2);
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("t3_accepted", acc_total, 3 * N);
        drain(1'b1, 400);

        // Early s_last: flagged, bank still closes at the eighth sample.
        m_ready = 1'b1;
        for (int i = 0; i < N; i++) send(DATA_W'(16'h300 + i), i == 4);
        chk("t4_frame_err", frame_err, 1'b1);
        drain(1'b0, 40);

        // Reset while the fourth beat is presented.
        apply_reset();
        for (int i = 0; i < N; i++) send(DATA_W'(16'h400 + i), i == N - 1);
        for (int n = 0; n < 20 && out_idx < 3; n++) tick();
        chk("t5_at_beat3", m_index, 3);
        apply_reset();
        for (int i = 0; i < N; i++) send(DATA_W'($urandom), i == N - 1);
        tick();
        tick();
        chk("t5_new_index0", m_index, 0);
        drain(1'b0, 40);

        // Final write to bank 1 lands on the same edge as bank 0's last beat.
        apply_reset();
        m_ready = 1'b1;
        for (int i = 0; i < N; i++) send(DATA_W'(16'hA0 + i), i == N - 1);
        tick();
        tick();
        chk("t6_valid_a", m_valid, 1'b1);
        for (int i = 0; i < N; i++) begin
            if (i == N - 1) chk("t6_coincide_last", m_last, 1'b1);
            send(DATA_W'(16'hB0 + i), i == N - 1);
        end
        chk("t6_banks_swap", banks_full, 2'b10);
        chk("t6_valid_gap0", m_valid, 1'b0);
        tick();
        chk("t6_valid_gap1", m_valid, 1'b0);
        tick();
        chk("t6_valid_b", m_valid, 1'b1);
        chk("t6_first_b", m_data, 16'hB0);
        drain(1'b0, 40);
        tick();
        tick();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
